xor_test_sequencer: RTL and testbench

Synchronous controller that sequences a gate-level XOR datapath (inputs X, Y; output F) through its full truth table and checks the result. It drives X/Y in Gray-code order, waits a programmable settle window to cover gate propagation delay, samples F, compares it against X^Y, and reports pass/fail and an error count. It is the self-check front end for the team's gate-delay combinational exercises.

---
 rtl/xor_test_sequencer_if.sv | 40 ++++
 rtl/xor_test_sequencer.sv | 155 +++++++++++++++
 tb/tb_xor_test_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/xor_test_sequencer_if.sv
// Port bundle between the XOR test sequencer and the datapath under test.
// master: sequencer side; slave: datapath / environment side.
interface xor_test_sequencer_if;
  logic       start;
  logic       F;
  logic       X;
  logic       Y;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] vec_idx;
  logic       glitch;

  modport master (
    input  start,
    input  F,
    output X,
    output Y,
    output busy,
    output done,
    output pass,
    output err_count,
    output vec_idx,
    output glitch
  );

  modport slave (
    output start,
    output F,
    input  X,
    input  Y,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  vec_idx,
    input  glitch
  );
endinterface

// File: rtl/xor_test_sequencer.sv
// Gray-order XOR truth-table sequencer with settle window and error count.
// Optional F hazard detector enabled by defining XOR_SEQ_GLITCH_CHECK_EN.
module xor_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                 Clock,
  input  logic                 Reset_b,
  xor_test_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LOAD =
    4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_n;
  logic       start_q;
  logic [3:0] cnt;
  logic [1:0] idx;
  logic [1:0] idx_n;
  logic       x_q;
  logic       y_q;
  logic [2:0] err;
  logic [2:0] err_n;
  logic       pass_q;
  logic       busy_q;
  logic       done_q;
  logic       accept;
  logic       load;
  logic       mismatch;
  logic       in_vec;

  assign mismatch = bus.F != (x_q ^ y_q);
  assign in_vec   = (state == SETTLE)
                  || (state == SAMPLE);

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    load    = 1'b0;
    idx_n   = idx;
    err_n   = err;
    unique case (state)
      IDLE: begin
        if (start_q) begin
          state_n = SETTLE;
          accept  = 1'b1;
          load    = 1'b1;
          idx_n   = 2'd0;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) state_n = SAMPLE;
      end
      SAMPLE: begin
        if (mismatch && err != 3'd4)
          err_n = err + 3'd1;
        if (idx == 2'd3) begin
          state_n = DONE;
        end else begin
          state_n = SETTLE;
          load    = 1'b1;
          idx_n   = idx + 2'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      state   <= IDLE;
      start_q <= 1'b0;
      cnt     <= 4'd0;
      idx     <= 2'd0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      err     <= 3'd0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      // start only registers while idle
      start_q <= bus.start
              && (state == IDLE);
      busy_q  <= (state_n == SETTLE)
              || (state_n == SAMPLE);
      done_q  <= state_n == DONE;
      if (load) begin
        idx <= idx_n;
        x_q <= idx_n[1];
        y_q <= ^idx_n;
        cnt <= CNT_LOAD;
      end else if (state == SETTLE
                   && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (accept) begin
        err    <= 3'd0;
        pass_q <= 1'b0;
      end else begin
        err <= err_n;
        if (state == SAMPLE && idx == 2'd3)
          pass_q <= err_n == 3'd0;
      end
    end
  end

`ifdef XOR_SEQ_GLITCH_CHECK_EN
  logic       f_q;
  logic [1:0] tcnt;
  logic       glitch_q;

  // one legal F edge per vector; a second one flags a hazard
  always_ff @(posedge Clock) begin
    if (!Reset_b) begin
      f_q      <= 1'b0;
      tcnt     <= 2'd0;
      glitch_q <= 1'b0;
    end else begin
      f_q <= bus.F;
      if (load) begin
        tcnt <= 2'd0;
      end else if (in_vec && bus.F != f_q) begin
        if (tcnt != 2'd2) tcnt <= tcnt + 2'd1;
        if (tcnt != 2'd0) glitch_q <= 1'b1;
      end
      if (accept) glitch_q <= 1'b0;
    end
  end

  assign bus.glitch = glitch_q;
`else
  assign bus.glitch = 1'b0;
`endif

  assign bus.X         = x_q;
  assign bus.Y         = y_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_count = err;
  assign bus.vec_idx   = idx;

endmodule

// File: tb/tb_xor_test_sequencer.sv
// Directed bench for xor_test_sequencer: delayed XOR, stuck, XNOR,
// start abuse, mid-run reset and an injected F double pulse.
module tb_xor_test_sequencer;

  logic clk = 1'b0;
  logic rst_b;
  logic fxd = 1'b0;
  logic inj;
  int   mode;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef XOR_SEQ_GLITCH_CHECK_EN
  localparam logic GEXP = 1'b1;
`else
  localparam logic GEXP = 1'b0;
`endif

  xor_test_sequencer_if bus ();

  xor_test_sequencer #(
    .SETTLE_CYCLES(4)
  ) dut (
    .Clock  (clk),
    .Reset_b(rst_b),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // gate-level XOR: 17 ns worst-case propagation
  always @(bus.X or bus.Y) begin
    #17;
    fxd = bus.X ^ bus.Y;
  end

  assign bus.F = ((mode == 0) ? fxd
               : (mode == 1) ? 1'b0
               : ~fxd) ^ inj;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ":X"}, 8'(bus.X), 8'd0);
    chk({tag, ":Y"}, 8'(bus.Y), 8'd0);
    chk({tag, ":busy"}, 8'(bus.busy), 8'd0);
    chk({tag, ":done"}, 8'(bus.done), 8'd0);
    chk({tag, ":pass"}, 8'(bus.pass), 8'd0);
    chk({tag, ":err"}, 8'(bus.err_count), 8'd0);
    chk({tag, ":idx"}, 8'(bus.vec_idx), 8'd0);
    chk({tag, ":glitch"}, 8'(bus.glitch), 8'd0);
  endtask

  task automatic full_run(input string tag,
                          input bit hold,
                          input bit repulse,
                          input bit pulse,
                          input logic [2:0] e_err,
                          input logic e_pass,
                          input logic e_glitch);
    int dones;
    int vi;
    logic [1:0] gray [4];
    gray = '{2'b00, 2'b01, 2'b11, 2'b10};
    dones = 0;
    bus.start = 1'b1;
    tick();
    if (!hold) bus.start = 1'b0;
    chk({tag, ":busy_e0"}, 8'(bus.busy), 8'd0);
    for (int e = 1; e <= 22; e++) begin
      if (repulse && e == 5) bus.start = 1'b1;
      if (hold && e == 22) bus.start = 1'b0;
      tick();
      if (repulse && e == 5) bus.start = 1'b0;
      if (bus.done === 1'b1) dones++;
      if (pulse && (e == 13 || e == 14)) begin
        #4;
        inj = (e == 13);
      end
      if (e % 5 == 1 && e <= 16) begin
        vi = (e - 1) / 5;
        chk($sformatf("%s:xy%0d", tag, vi),
            8'({bus.X, bus.Y}), 8'(gray[vi]));
        chk($sformatf("%s:idx%0d", tag, vi),
            8'(bus.vec_idx), 8'(vi));
      end
      if (e == 1) begin
        chk({tag, ":pass_clr"}, 8'(bus.pass), 8'd0);
        chk({tag, ":err_clr"}, 8'(bus.err_count), 8'd0);
        chk({tag, ":glitch_clr"},
            8'(bus.glitch), 8'd0);
      end
      if (e == 20) begin
        chk({tag, ":done_e20"}, 8'(bus.done), 8'd0);
        chk({tag, ":busy_e20"}, 8'(bus.busy), 8'd1);
      end
      if (e == 21) begin
        chk({tag, ":done_e21"}, 8'(bus.done), 8'd1);
        chk({tag, ":busy_e21"}, 8'(bus.busy), 8'd0);
        chk({tag, ":err"}, 8'(bus.err_count),
            8'(e_err));
        chk({tag, ":pass"}, 8'(bus.pass), 8'(e_pass));
        chk({tag, ":glitch"}, 8'(bus.glitch),
            8'(e_glitch));
      end
      if (e == 22)
        chk({tag, ":done_e22"}, 8'(bus.done), 8'd0);
    end
    chk({tag, ":n_done"}, 8'(dones), 8'd1);
    tick();
    tick();
  endtask

  initial begin
    rst_b     = 1'b0;
    bus.start = 1'b0;
    inj       = 1'b0;
    mode      = 0;
    repeat (3) tick();
    chk_zero("reset");
    rst_b = 1'b1;
    repeat (3) tick();

    full_run("xor", 0, 0, 0, 3'd0, 1'b1, 1'b0);
    mode = 1;
    repeat (3) tick();
    full_run("stuck0", 0, 0, 0, 3'd2, 1'b0, 1'b0);
    mode = 2;
    repeat (3) tick();
    full_run("xnor", 0, 0, 0, 3'd4, 1'b0, 1'b0);
    mode = 0;
    repeat (3) tick();
    full_run("hold", 1, 0, 0, 3'd0, 1'b1, 1'b0);
    full_run("repulse", 0, 1, 0, 3'd0, 1'b1, 1'b0);

    mode = 2;
    repeat (3) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (9) tick();
    chk("midrun:err", 8'(bus.err_count), 8'd1);
    chk("midrun:idx", 8'(bus.vec_idx), 8'd1);
    chk("midrun:busy", 8'(bus.busy), 8'd1);
    rst_b     = 1'b0;
    bus.start = 1'b1;
    tick();
    chk_zero("midrst");
    tick();
    chk("midrst:busy_held", 8'(bus.busy), 8'd0);
    rst_b     = 1'b0;
    bus.start = 1'b0;
    tick();
    rst_b = 1'b1;
    repeat (3) tick();
    chk("postrst:idle", 8'(bus.busy), 8'd0);
    mode = 0;
    repeat (3) tick();
    full_run("post_rst", 0, 0, 0, 3'd0, 1'b1, 1'b0);

    full_run("glitch", 0, 0, 1, 3'd0, 1'b1, GEXP);
    full_run("clear", 0, 0, 0, 3'd0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
